count_display: RTL and testbench

- Downstream consumer of the 8-bit free-running `counter` stage.
- Samples `count_in` whenever its value changes and converts it to 3-digit BCD with a sequential double-dabble engine (one bit per cycle).
- Drives a time-multiplexed 3-digit 7-segment display and exposes the BCD result for checking.
- Sits between `counter.out` and the board display pins.

---
 rtl/count_display_pkg.sv | 44 ++++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/count_display.sv | 78 +++++++
 tb/tb_count_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/count_display_pkg.sv
// Shared types and constants for count_display: FSM state enum, BCD widths,
// 7-segment patterns (active-high, bit0=a .. bit6=g) and the nibble encoder.
package count_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS = 3;
  localparam int BCD_W  = 12;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: captures count_in whenever it differs
// from the last captured value and converts it one bit per clock.
//
// state | meaning
// IDLE  | compare count_in against last_val, capture on change
// SHIFT | 8 add-3/shift steps on {acc, bin}
// DONE  | publish accumulator to bcd_out
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       count_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [7:0]       last_q, last_d;
  logic [7:0]       bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] adj;
  logic [BCD_W+7:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    adj     = acc_q;
    sh      = '0;
    case (state_q)
      IDLE: begin
        if (count_in != last_q) begin
          bin_d   = count_in;
          acc_d   = '0;
          last_d  = count_in;
          cnt_d   = 3'd7;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        sh    = {adj, bin_q} << 1;
        acc_d = sh[BCD_W+7:8];
        bin_d = sh[7:0];
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) state_d = DONE;
      end
      DONE: begin
        bcd_d   = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd_out = bcd_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: rtl/count_display.sv
// Binary-to-BCD conversion of count_in plus a time-multiplexed 3-digit
// 7-segment scan. Define COUNT_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zeros.
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       count_in,
  output logic [BCD_W-1:0] bcd_out,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [2:0]       dig_en
);

  localparam int SCAN_W = 16;

  logic [BCD_W-1:0]  disp;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;
  logic [6:0]        seg_q, seg_d;
  logic [2:0]        dig_en_q, dig_en_d;
  logic [3:0]        nib;
  logic              blank;

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_in (count_in),
    .bcd_out  (disp),
    .busy     (busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q   <= '0;
      digit_q  <= '0;
      seg_q    <= '0;
      dig_en_q <= '0;
    end else begin
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  always_comb begin
    scan_d  = scan_q + SCAN_W'(1);
    digit_d = digit_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d  = '0;
      digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
    end
  end

  // disp only changes in DONE, so the mux never sees a partial conversion
  always_comb begin
    blank = 1'b0;
    case (digit_q)
      2'd1:    nib = disp[7:4];
      2'd2:    nib = disp[11:8];
      default: nib = disp[3:0];
    endcase
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
    if (digit_q == 2'd2) blank = (disp[11:8] == 4'd0);
    if (digit_q == 2'd1) blank = (disp[11:4] == 8'd0);
`endif
    seg_d    = blank ? SEG_BLANK : seg_encode(nib);
    dig_en_d = 3'b001 << digit_q;
  end

  assign bcd_out = disp;
  assign seg     = seg_q;
  assign dig_en  = dig_en_q;

endmodule

// File: tb/tb_count_display.sv
// Directed self-checking bench for count_display with SCAN_DIV=4.
module tb_count_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  count_in;
  logic [11:0] bcd_out;
  logic        busy;
  logic [6:0]  seg;
  logic [2:0]  dig_en;

  int n_cmp = 0;
  int n_err = 0;

  count_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_in (count_in),
    .bcd_out  (bcd_out),
    .busy     (busy),
    .seg      (seg),
    .dig_en   (dig_en)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next edge is the capture edge; counts edges after which busy is high.
  task automatic run_conv(input logic [7:0] val, input logic [11:0] exp, input string name);
    int cnt = 0;
    count_in = val;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) cnt++;
      else break;
    end
    n_cmp++;
    if (cnt !== 9) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d expected 9", name, cnt);
    end
    n_cmp++;
    if (bcd_out !== exp) begin
      n_err++;
      $display("FAIL %s bcd_out: got %h expected %h", name, bcd_out, exp);
    end
  endtask

  task automatic check_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                            input int rounds, input string name);
    logic [2:0] prev;
    logic [2:0] exp_en;
    logic [6:0] exp_seg;
    bit found = 0;
    prev = dig_en;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dig_en === 3'b001 && prev !== 3'b001) begin
        found = 1;
        break;
      end
      prev = dig_en;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL %s scan_sync: no dig_en rise to 001, last %b", name, dig_en);
      return;
    end
    for (int k = 0; k < 12 * rounds; k++) begin
      if (k > 0) tick();
      case ((k / 4) % 3)
        0: begin exp_en = 3'b001; exp_seg = s0; end
        1: begin exp_en = 3'b010; exp_seg = s1; end
        default: begin exp_en = 3'b100; exp_seg = s2; end
      endcase
      n_cmp++;
      if (dig_en !== exp_en || seg !== exp_seg) begin
        n_err++;
        $display("FAIL %s scan k=%0d: got dig_en=%b seg=%h expected dig_en=%b seg=%h",
                 name, k, dig_en, seg, exp_en, exp_seg);
      end
    end
  endtask

  task automatic test_reset();
    int cnt = 0;
    rst_n = 1'b0;
    count_in = 8'd37;
    #100;
    n_cmp++;
    if (seg !== 7'h00 || dig_en !== 3'b000 || busy !== 1'b0 || bcd_out !== 12'h000) begin
      n_err++;
      $display("FAIL reset_values: got seg=%h dig_en=%b busy=%b bcd=%h expected 00/000/0/000",
               seg, dig_en, busy, bcd_out);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (dig_en !== 3'b001 || seg !== 7'h3F || busy !== 1'b1) begin
      n_err++;
      $display("FAIL first_edge: got dig_en=%b seg=%h busy=%b expected 001/3f/1", dig_en, seg, busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (busy) cnt++;
    end
    n_cmp++;
    if (cnt !== 8 || bcd_out !== 12'h000) begin
      n_err++;
      $display("FAIL reset_conv_latency: got busy=%0d bcd=%h after E8 expected 8/000", cnt, bcd_out);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || bcd_out !== 12'h037) begin
      n_err++;
      $display("FAIL reset_conv_37: got busy=%b bcd=%h expected 0/037", busy, bcd_out);
    end
  endtask

  task automatic test_conversion();
    run_conv(8'd0,   12'h000, "conv_0");
    run_conv(8'd255, 12'h255, "conv_255");
    run_conv(8'd100, 12'h100, "conv_100");
    run_conv(8'd9,   12'h009, "conv_9");
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0 || bcd_out !== 12'h009) begin
        n_err++;
        $display("FAIL unchanged_input: got busy=%b bcd=%h expected 0/009", busy, bcd_out);
      end
    end
  endtask

  task automatic test_scan();
    run_conv(8'd123, 12'h123, "conv_123");
    check_scan(7'h4F, 7'h5B, 7'h06, 3, "scan_123");
  endtask

  task automatic test_back_to_back();
    int cnt = 0;
    count_in = 8'd10;
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_capture: got busy=%b expected 1", busy);
    end
    tick(); tick(); tick();
    count_in = 8'd200;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) cnt++;
      else break;
    end
    n_cmp++;
    if (cnt !== 5 || bcd_out !== 12'h010) begin
      n_err++;
      $display("FAIL mid_change_first: got busy_rest=%0d bcd=%h expected 5/010", cnt, bcd_out);
    end
    run_conv(8'd200, 12'h200, "mid_change_second");
  endtask

  task automatic test_async_reset();
    count_in = 8'd99;
    tick();
    tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || bcd_out !== 12'h000 || seg !== 7'h00 || dig_en !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b bcd=%h seg=%h dig_en=%b expected 0/000/00/000",
               busy, bcd_out, seg, dig_en);
    end
    tick(); tick();
    rst_n = 1'b1;
    run_conv(8'd99, 12'h099, "reconv_99");
  endtask

  task automatic test_leading_zero();
    run_conv(8'd7, 12'h007, "conv_7");
`ifdef COUNT_DISPLAY_LEADING_ZERO_BLANK_EN
    check_scan(7'h07, 7'h00, 7'h00, 1, "blank_7");
    run_conv(8'd0, 12'h000, "conv_0b");
    check_scan(7'h3F, 7'h00, 7'h00, 1, "blank_0");
`else
    check_scan(7'h07, 7'h3F, 7'h3F, 1, "noblank_7");
    run_conv(8'd0, 12'h000, "conv_0b");
    check_scan(7'h3F, 7'h3F, 7'h3F, 1, "noblank_0");
`endif
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_scan();
    test_back_to_back();
    test_async_reset();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
